pipe_hazard_scoreboard: RTL and testbench

Parametrised hazard, forwarding and flush controller for the 5-stage MIPS pipeline. It replaces the fixed load-use/forwarding logic with one block that also tracks in-flight fixed-latency multi-cycle ops (mul/div) in a small scoreboard. It sits beside ID/EX and drives PC/IF-ID write enables, ID/EX and IF/ID flushes, and the ALU operand forward selects.

---
 rtl/pipe_hazard_scoreboard.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline, with a small
// scoreboard tracking in-flight fixed-latency multi-cycle (mul/div) results.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_scoreboard #(
  parameter int unsigned AW       = 5,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned MC_DEPTH = 2
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_is_mc,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] ex_wr_reg,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_branch_taken,
  input  logic [AW-1:0] mem_wr_reg,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_wr_reg,
  input  logic          wb_regwrite,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mc_full,
  output logic          mc_retire,
  output logic [AW-1:0] mc_retire_reg
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_events
  , output logic [CNT_W-1:0] mc_stall_cycles
`endif
);

  localparam int unsigned CntW = $clog2(MC_LAT);
  localparam logic [CntW-1:0] CntInit = CntW'(MC_LAT - 1);

  logic [MC_DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]       ent_reg_q [MC_DEPTH];
  logic [AW-1:0]       ent_reg_d [MC_DEPTH];
  logic [CntW-1:0]     ent_cnt_q [MC_DEPTH];
  logic [CntW-1:0]     ent_cnt_d [MC_DEPTH];

  logic rs_live, rt_live, rd_live;
  logic load_use, sb_raw, sb_waw, struct_haz;
  logic stall, issue, alloc, alloc_done;

  // Forward selects: EX/MEM beats MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_wr_reg != '0) && (mem_wr_reg == ex_rs)) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite && (wb_wr_reg != '0) && (wb_wr_reg == ex_rs)) begin
      fwd_a = 2'b01;
    end
    if (mem_regwrite && (mem_wr_reg != '0) && (mem_wr_reg == ex_rt)) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite && (wb_wr_reg != '0) && (wb_wr_reg == ex_rt)) begin
      fwd_b = 2'b01;
    end
  end

  // Hazard detection against EX load and scoreboard entries; also picks the retiring entry.
  always_comb begin
    rs_live       = id_uses_rs & (id_rs != '0);
    rt_live       = id_uses_rt & (id_rt != '0);
    rd_live       = id_regwrite & (id_rd != '0);
    load_use      = ex_memread & ex_regwrite & (ex_wr_reg != '0) &
                    ((rs_live & (id_rs == ex_wr_reg)) | (rt_live & (id_rt == ex_wr_reg)));
    sb_raw        = 1'b0;
    sb_waw        = 1'b0;
    mc_retire     = 1'b0;
    mc_retire_reg = '0;
    for (int unsigned i = 0; i < MC_DEPTH; i++) begin
      if (valid_q[i]) begin
        if ((rs_live && (ent_reg_q[i] == id_rs)) || (rt_live && (ent_reg_q[i] == id_rt))) begin
          sb_raw = 1'b1;
        end
        if (rd_live && (ent_reg_q[i] == id_rd)) begin
          sb_waw = 1'b1;
        end
        // Fixed latency and single issue guarantee at most one zero count at a time.
        if ((ent_cnt_q[i] == '0) && !mc_retire) begin
          mc_retire     = 1'b1;
          mc_retire_reg = ent_reg_q[i];
        end
      end
    end
    mc_full    = &valid_q;
    struct_haz = id_is_mc & id_regwrite & mc_full & ~mc_retire;
    stall      = id_valid & (load_use | sb_raw | sb_waw | struct_haz) & ~ex_branch_taken;
    issue      = id_valid & ~stall & ~ex_branch_taken;
    alloc      = issue & id_is_mc & rd_live;
  end

  // Pipeline control: a taken branch overrides any stall.
  always_comb begin
    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = ex_branch_taken;
    idex_flush = stall | ex_branch_taken;
  end

  // Scoreboard next state: count down, free at zero, allocate lowest free (or freeing) slot.
  always_comb begin
    valid_d    = valid_q;
    ent_reg_d  = ent_reg_q;
    ent_cnt_d  = ent_cnt_q;
    alloc_done = 1'b0;
    for (int unsigned i = 0; i < MC_DEPTH; i++) begin
      if (valid_q[i]) begin
        if (ent_cnt_q[i] == '0) begin
          valid_d[i] = 1'b0;
        end else begin
          ent_cnt_d[i] = ent_cnt_q[i] - CntW'(1);
        end
      end
    end
    for (int unsigned i = 0; i < MC_DEPTH; i++) begin
      if (alloc && !alloc_done && (!valid_q[i] || (ent_cnt_q[i] == '0))) begin
        valid_d[i]   = 1'b1;
        ent_reg_d[i] = id_rd;
        ent_cnt_d[i] = CntInit;
        alloc_done   = 1'b1;
      end
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < MC_DEPTH; i++) begin
        ent_reg_q[i] <= '0;
        ent_cnt_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      ent_reg_q <= ent_reg_d;
      ent_cnt_q <= ent_cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic mc_only_stall;
  assign mc_only_stall = stall & (sb_raw | sb_waw | struct_haz) & ~load_use;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      mc_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (ex_branch_taken && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
      if (mc_only_stall && (mc_stall_cycles != '1)) begin
        mc_stall_cycles <= mc_stall_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: a vector table for the combinational
// forwarding/load-use/branch paths plus hand-written multi-cycle scoreboard sequences.
module tb_pipe_hazard_scoreboard;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_is_mc;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [AW-1:0] ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic          ex_regwrite, ex_memread, ex_branch_taken, mem_regwrite, wb_regwrite;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, mc_full, mc_retire;
  logic [1:0]    fwd_a, fwd_b;
  logic [AW-1:0] mc_retire_reg;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_events, mc_stall_cycles;
`endif

  int passed = 0;
  int total  = 0;

  pipe_hazard_scoreboard #(
    .AW       (AW),
    .MC_LAT   (4),
    .MC_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_is_mc        (id_is_mc),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_wr_reg       (ex_wr_reg),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_wr_reg      (mem_wr_reg),
    .mem_regwrite    (mem_regwrite),
    .wb_wr_reg       (wb_wr_reg),
    .wb_regwrite     (wb_regwrite),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mc_full         (mc_full),
    .mc_retire       (mc_retire),
    .mc_retire_reg   (mc_retire_reg)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles    (stall_cycles)
    , .flush_events    (flush_events)
    , .mc_stall_cycles (mc_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [AW-1:0] ex_rs, ex_rt;
    logic          mem_rw;
    logic [AW-1:0] mem_reg;
    logic          wb_rw;
    logic [AW-1:0] wb_reg;
    logic          ex_memread, ex_regwrite;
    logic [AW-1:0] ex_wr;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt;
    logic          uses_rs, uses_rt, branch;
    logic          exp_pc, exp_idex, exp_ifid;
    logic [1:0]    exp_fa, exp_fb;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_is_mc = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    ex_rs = 0; ex_rt = 0; ex_wr_reg = 0; ex_regwrite = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_wr_reg = 0; mem_regwrite = 0; wb_wr_reg = 0; wb_regwrite = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mc(input logic [AW-1:0] rd);
    id_valid = 1; id_is_mc = 1; id_regwrite = 1; id_rd = rd;
    id_uses_rs = 0; id_uses_rt = 0;
  endtask

  logic seen;

  initial begin
    //                 name       ex_rs ex_rt mrw mreg  wrw wreg  mrd  erw  ewr  idv  id_rs id_rt urs  urt  br   pc   idex ifid fa     fb
    vecs[0]  = '{"fwd_mem",  5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00};
    vecs[1]  = '{"fwd_wb",   5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00};
    vecs[2]  = '{"fwd_r0",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[3]  = '{"fwd_split", 5'd4, 5'd7, 1'b1, 5'd7, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10};
    vecs[4]  = '{"lu_rs",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{"lu_unused", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[6]  = '{"lu_rt",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 5'd5,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[7]  = '{"lu_r0",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[8]  = '{"lu_idinv", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{"lu_branch", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[10] = '{"lu_norw",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};

    clear_inputs();
    reset = 0;
    #12;
    chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
    chk("rst_flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_mc", {31'd0, mc_full}, 32'd0);
    chk("rst_retire", {26'd0, mc_retire, mc_retire_reg}, 32'd0);
    tick();
    reset = 1;
    tick();

    // Combinational table (scoreboard empty, no mc ops).
    for (int i = 0; i < 11; i++) begin
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
      mem_regwrite = vecs[i].mem_rw; mem_wr_reg = vecs[i].mem_reg;
      wb_regwrite = vecs[i].wb_rw; wb_wr_reg = vecs[i].wb_reg;
      ex_memread = vecs[i].ex_memread; ex_regwrite = vecs[i].ex_regwrite;
      ex_wr_reg = vecs[i].ex_wr; id_valid = vecs[i].id_valid;
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
      id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
      ex_branch_taken = vecs[i].branch;
      #1;
      chk({vecs[i].name, "_pc"}, {31'd0, pc_write}, {31'd0, vecs[i].exp_pc});
      chk({vecs[i].name, "_ifidw"}, {31'd0, ifid_write}, {31'd0, vecs[i].exp_pc});
      chk({vecs[i].name, "_idex"}, {31'd0, idex_flush}, {31'd0, vecs[i].exp_idex});
      chk({vecs[i].name, "_ifid"}, {31'd0, ifid_flush}, {31'd0, vecs[i].exp_ifid});
      chk({vecs[i].name, "_fa"}, {30'd0, fwd_a}, {30'd0, vecs[i].exp_fa});
      chk({vecs[i].name, "_fb"}, {30'd0, fwd_b}, {30'd0, vecs[i].exp_fb});
      tick();
    end
    clear_inputs();
    tick();

    // MC RAW: mul to r8 issues at E0, reader of r8 stalls cycles 1..4.
    set_mc(5'd8);
    #1;
    chk("raw_issue_pc", {31'd0, pc_write}, 32'd1);
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 5'd8; id_uses_rs = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("raw_stall_c%0d", k), {30'd0, pc_write, idex_flush}, 32'b01);
      chk($sformatf("raw_retire_c%0d", k), {31'd0, mc_retire}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("raw_retire_reg", {27'd0, mc_retire_reg}, 32'd8);
      tick();
    end
    #1;
    chk("raw_clear_c5", {30'd0, pc_write, mc_retire}, 32'b10);
    clear_inputs();
    tick();

    // WAW: mc write to r6 in flight, a later writer of r6 stalls.
    set_mc(5'd6);
    tick();
    clear_inputs();
    id_valid = 1; id_regwrite = 1; id_rd = 5'd6;
    #1;
    chk("waw_stall", {31'd0, pc_write}, 32'd0);
    clear_inputs();
    for (int k = 0; k < 5; k++) tick();

    // Structural: r9, r10 fill the scoreboard; r11 waits for r9's retire cycle.
    set_mc(5'd9);
    #1;
    chk("st_empty", {31'd0, mc_full}, 32'd0);
    tick();
    set_mc(5'd10);
    tick();
    set_mc(5'd11);
    #1;
    chk("st_full_c2", {31'd0, mc_full}, 32'd1);
    chk("st_stall_c2", {31'd0, pc_write}, 32'd0);
    tick();
    #1;
    chk("st_stall_c3", {30'd0, pc_write, mc_retire}, 32'b00);
    tick();
    #1;
    chk("st_retire_c4", {26'd0, mc_retire, mc_retire_reg}, {26'd0, 1'b1, 5'd9});
    chk("st_issue_c4", {31'd0, pc_write}, 32'd1);
    tick();
    clear_inputs();
    #1;
    chk("st_full_c5", {31'd0, mc_full}, 32'd1);
    chk("st_retire_c5", {26'd0, mc_retire, mc_retire_reg}, {26'd0, 1'b1, 5'd10});
    tick();
    #1;
    chk("st_c6", {30'd0, mc_full, mc_retire}, 32'b00);
    tick();
    tick();
    #1;
    chk("st_retire_c8", {26'd0, mc_retire, mc_retire_reg}, {26'd0, 1'b1, 5'd11});
    tick();
    #1;
    chk("st_c9", {31'd0, mc_retire}, 32'd0);
    tick();

    // Branch beats a load-use stall and blocks allocation of an mc op.
    set_mc(5'd12);
    id_rs = 5'd5; id_uses_rs = 1;
    ex_memread = 1; ex_regwrite = 1; ex_wr_reg = 5'd5; ex_branch_taken = 1;
    #1;
    chk("br_flushes", {29'd0, ifid_flush, idex_flush, pc_write}, 32'b111);
    tick();
    clear_inputs();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mc_retire || mc_full) seen = 1;
      tick();
    end
    chk("br_no_alloc", {31'd0, seen}, 32'd0);

    // Reset with two entries live drops them and produces no retire.
    set_mc(5'd13);
    tick();
    set_mc(5'd14);
    tick();
    clear_inputs();
    #1;
    chk("rm_full", {31'd0, mc_full}, 32'd1);
    reset = 0;
    #1;
    chk("rm_full_rst", {30'd0, mc_full, mc_retire}, 32'b00);
`ifdef HAZ_PERF_CNT_EN
    chk("rm_cnt_stall", stall_cycles, 32'd0);
    chk("rm_cnt_flush", flush_events, 32'd0);
    chk("rm_cnt_mc", mc_stall_cycles, 32'd0);
`endif
    tick();
    reset = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mc_retire) seen = 1;
      tick();
    end
    chk("rm_no_retire", {31'd0, seen}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
